// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared rate enumeration, calibration FSM states and nominal-period helpers
// used by the auto-baud controller and the baud clock generator.
package uart_autobaud_ctrl_pkg;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_FALL,
    S_MEAS1,
    S_WAIT_FALL2,
    S_MEAS2,
    S_DECIDE,
    S_LOCK,
    S_FAIL
  } ab_state_e;

  typedef struct packed {
    logic  valid;
    baud_e rate;
  } class_t;

  function automatic int unsigned rate_hz(input baud_e sel);
    int unsigned rate;
    case (sel)
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      BAUD_57600: rate = 57600;
      default:    rate = 115200;
    endcase
    return rate;
  endfunction

  // Rounded to the nearest clock, so 100 MHz / 9600 gives 10417.
  function automatic int unsigned nominal_period(input int unsigned clk_freq, input baud_e sel);
    return (clk_freq + rate_hz(sel) / 2) / rate_hz(sel);
  endfunction

  function automatic int unsigned win_lo(input int unsigned per, input int unsigned tol_pct);
    return per * (100 - tol_pct) / 100;
  endfunction

  function automatic int unsigned win_hi(input int unsigned per, input int unsigned tol_pct);
    return per * (100 + tol_pct) / 100;
  endfunction

endpackage

// File: rtl/uart_rx_edge_det.sv
// Two-flop synchroniser for the asynchronous rx line, plus single-cycle
// rise/fall pulses derived from the synchronised level.
module uart_rx_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: reset to the idle-high line level so leaving reset never fakes a start edge.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rx_s_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times two low pulses of a 0x55 calibration character,
// classifies them to one of four rates and drives the baud generator.
module uart_autobaud_ctrl
  import uart_autobaud_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TOL_PCT   = 12,
  parameter int unsigned IDLE_BITS = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       rx_i,
  output logic [1:0] baud_sel_o,
  output logic       gen_en_o,
  output logic       locked_o,
  output logic       busy_o,
  output logic       error_o
);

  localparam int unsigned PER0  = nominal_period(CLK_FREQ, BAUD_9600);
  localparam int unsigned PER1  = nominal_period(CLK_FREQ, BAUD_19200);
  localparam int unsigned PER2  = nominal_period(CLK_FREQ, BAUD_57600);
  localparam int unsigned PER3  = nominal_period(CLK_FREQ, BAUD_115200);
  localparam int unsigned CNT_W = $clog2(2 * PER0 + 1);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(2 * PER0);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_BITS * PER0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [CNT_W-1:0] LO0 = CNT_W'(win_lo(PER0, TOL_PCT));
  localparam logic [CNT_W-1:0] HI0 = CNT_W'(win_hi(PER0, TOL_PCT));
  localparam logic [CNT_W-1:0] LO1 = CNT_W'(win_lo(PER1, TOL_PCT));
  localparam logic [CNT_W-1:0] HI1 = CNT_W'(win_hi(PER1, TOL_PCT));
  localparam logic [CNT_W-1:0] LO2 = CNT_W'(win_lo(PER2, TOL_PCT));
  localparam logic [CNT_W-1:0] HI2 = CNT_W'(win_hi(PER2, TOL_PCT));
  localparam logic [CNT_W-1:0] LO3 = CNT_W'(win_lo(PER3, TOL_PCT));
  localparam logic [CNT_W-1:0] HI3 = CNT_W'(win_hi(PER3, TOL_PCT));

  if (HI3 >= LO2 || HI2 >= LO1 || HI1 >= LO0) begin : g_bad_windows
    $error("uart_autobaud_ctrl: rate windows overlap for TOL_PCT=%0d", TOL_PCT);
  end
  if (IDLE_BITS < 1 || IDLE_BITS > 2) begin : g_bad_idle
    $error("uart_autobaud_ctrl: IDLE_BITS=%0d does not fit the counter", IDLE_BITS);
  end

  // Fastest rate first; the first window that contains the count wins.
  function automatic class_t classify(input logic [CNT_W-1:0] cnt);
    class_t c;
    c = '{valid: 1'b0, rate: BAUD_115200};
    if (cnt >= LO3 && cnt <= HI3)      c = '{valid: 1'b1, rate: BAUD_115200};
    else if (cnt >= LO2 && cnt <= HI2) c = '{valid: 1'b1, rate: BAUD_57600};
    else if (cnt >= LO1 && cnt <= HI1) c = '{valid: 1'b1, rate: BAUD_19200};
    else if (cnt >= LO0 && cnt <= HI0) c = '{valid: 1'b1, rate: BAUD_9600};
    return c;
  endfunction

  logic rx_s, rx_rise, rx_fall;

  uart_rx_edge_det u_edge_det (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rx_i   (rx_i),
    .rx_s_o (rx_s),
    .rise_o (rx_rise),
    .fall_o (rx_fall)
  );

  ab_state_e        state_q;
  logic [CNT_W-1:0] count_q, count_inc;
  class_t           c1_q, c2_q;
  baud_e            baud_sel_q;
  logic             gen_en_q, locked_q, busy_q, error_q;

  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      baud_sel_q <= BAUD_115200;
      gen_en_q   <= 1'b0;
      locked_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          state_q  <= S_WAIT_IDLE;
          count_q  <= '0;
          busy_q   <= 1'b1;
          error_q  <= 1'b0;
          locked_q <= 1'b0;
          gen_en_q <= 1'b0;
        end
        S_WAIT_IDLE: begin
          if (count_q == IDLE_LIM) state_q <= S_WAIT_FALL;
          else if (rx_s)           count_q <= count_inc;
          else                     count_q <= '0;
        end
        S_WAIT_FALL: if (rx_fall) begin
          state_q <= S_MEAS1;
          count_q <= CNT_W'(1);
        end
        S_MEAS1: begin
          if (rx_rise) begin
            c1_q    <= classify(count_q);
            state_q <= S_WAIT_FALL2;
            count_q <= CNT_W'(1);
          end else if (count_q == LIMIT) state_q <= S_FAIL;
          else                           count_q <= count_inc;
        end
        S_WAIT_FALL2: begin
          if (rx_fall) begin
            state_q <= S_MEAS2;
            count_q <= CNT_W'(1);
          end else if (count_q == LIMIT) state_q <= S_FAIL;
          else                           count_q <= count_inc;
        end
        S_MEAS2: begin
          if (rx_rise) begin
            c2_q    <= classify(count_q);
            state_q <= S_DECIDE;
          end else if (count_q == LIMIT) state_q <= S_FAIL;
          else                           count_q <= count_inc;
        end
        S_DECIDE: begin
          if (c1_q.valid && c1_q == c2_q) begin
            state_q    <= S_LOCK;
            baud_sel_q <= c1_q.rate;
            locked_q   <= 1'b1;
            gen_en_q   <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= S_FAIL;
          end
        end
        S_LOCK: state_q <= S_IDLE;
        S_FAIL: begin
          state_q  <= S_IDLE;
          error_q  <= 1'b1;
          locked_q <= 1'b0;
          gen_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign baud_sel_o = baud_sel_q;
  assign gen_en_o   = gen_en_q;
  assign locked_o   = locked_q;
  assign busy_o     = busy_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed bench for uart_autobaud_ctrl at a 10 MHz clock (PER 1042/521/174/87,
// windows 916..1167 / 458..583 / 153..194 / 76..97, stuck-low limit 2084).
module tb_uart_autobaud_ctrl;

  localparam int unsigned IDLE_HOLD = 2200;

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, rx_i;
  logic [1:0] baud_sel_o;
  logic       gen_en_o, locked_o, busy_o, error_o;

  int n_vec = 0;
  int n_err = 0;

  uart_autobaud_ctrl #(
    .CLK_FREQ  (10_000_000),
    .TOL_PCT   (12),
    .IDLE_BITS (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .rx_i       (rx_i),
    .baud_sel_o (baud_sel_o),
    .gen_en_o   (gen_en_o),
    .locked_o   (locked_o),
    .busy_o     (busy_o),
    .error_o    (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] baud, input logic gen,
                           input logic lock, input logic bsy, input logic err);
    check({tag, ".baud_sel"}, 16'(baud_sel_o), 16'(baud));
    check({tag, ".gen_en"},   16'(gen_en_o),   16'(gen));
    check({tag, ".locked"},   16'(locked_o),   16'(lock));
    check({tag, ".busy"},     16'(busy_o),     16'(bsy));
    check({tag, ".error"},    16'(error_o),    16'(err));
  endtask

  // Ends 1 time unit after the edge at which the controller accepted start.
  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  // Idle-high preamble then low l1, high h, low l2; ends just after the final rise.
  task automatic send_char(input int l1, input int h, input int l2);
    repeat (IDLE_HOLD) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (l1) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (h) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (l2) @(posedge clk_i);
    #1 rx_i = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    rx_i    = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_out("reset", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // 115200 with exact lock latency: low before edge 4, high after it.
    pulse_start();
    @(negedge clk_i);
    check_out("start", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    send_char(87, 87, 87);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("lat3.locked", 16'(locked_o), 16'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    check_out("b115200", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Line activity while not calibrating has no effect.
    #1 rx_i = 1'b0;
    repeat (87) @(posedge clk_i);
    #1 rx_i = 1'b1;
    repeat (87) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (87) @(posedge clk_i);
    #1 rx_i = 1'b1;
    settle();
    check_out("idle_rx", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    pulse_start();
    send_char(1042, 1042, 1042);
    settle();
    check_out("b9600", 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    pulse_start();
    send_char(191, 174, 191);
    settle();
    check_out("b57600_slow", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    pulse_start();
    send_char(87, 87, 174);
    settle();
    check_out("mismatch", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    pulse_start();
    @(negedge clk_i);
    check_out("err_clear", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_char(70, 87, 70);
    settle();
    check_out("no_window", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    pulse_start();
    send_char(98, 87, 98);
    settle();
    check_out("above_hi3", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);

    pulse_start();
    send_char(76, 87, 76);
    settle();
    check_out("lo3_edge", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    pulse_start();
    send_char(97, 87, 97);
    settle();
    check_out("hi3_edge", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // Stuck low: count hits 2084 after edge 2086, FAIL at 2087, error at 2088.
    // A start in the middle must not restart the sequence.
    pulse_start();
    repeat (IDLE_HOLD) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (500) @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (2087 - 501) @(posedge clk_i);
    @(negedge clk_i);
    check_out("stuck_pre", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    check_out("stuck_fail", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rx_i = 1'b1;

    pulse_start();
    send_char(174, 174, 174);
    settle();
    check_out("b57600", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    pulse_start();
    @(negedge clk_i);
    check_out("restart", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    send_char(521, 521, 521);
    settle();
    check_out("b19200", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset while measuring the first low pulse.
    pulse_start();
    repeat (IDLE_HOLD) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (30) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check_out("rst_meas1", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    rx_i = 1'b1;
    settle();
    check_out("post_rst", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
